// File: rtl/la_pkg.sv
// Shared constants for the logic-analyzer capture path: state encoding,
// default sample-RAM address width and sample width.
package la_pkg;
  localparam int LA_ADDR_W = 10;
  localparam int LA_SMP_W  = 8;

  localparam logic [4:0] ST_IDLE = 5'b00001;
  localparam logic [4:0] ST_PRE  = 5'b00010;
  localparam logic [4:0] ST_WAIT = 5'b00100;
  localparam logic [4:0] ST_POST = 5'b01000;
  localparam logic [4:0] ST_DONE = 5'b10000;
endpackage

// File: rtl/la_delay_line.sv
// Fixed-length sample delay that lines raw LA samples up with the
// trigger detector's output. STAGES=0 is a plain wire.
module la_delay_line
  import la_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [LA_SMP_W-1:0] DIN,
  output logic [LA_SMP_W-1:0] DOUT
);

  generate
    if (STAGES == 0) begin : g_pass
      assign DOUT = DIN;
    end else begin : g_shift
      logic [LA_SMP_W-1:0] stg_p [STAGES];

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          for (int i = 0; i < STAGES; i++) stg_p[i] <= '0;
        end else begin
          stg_p[0] <= DIN;
          for (int i = 1; i < STAGES; i++) stg_p[i] <= stg_p[i-1];
        end
      end

      assign DOUT = stg_p[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/la_capture_ctrl.sv
// Capture controller: streams decimated samples into a circular RAM,
// guarantees PRE_CNT pre-trigger samples, then fills the rest after trigger.
module la_capture_ctrl
  import la_pkg::*;
#(
  parameter int ADDR_W   = LA_ADDR_W,
  parameter int TRIG_LAG = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic [LA_SMP_W-1:0] DATA_IN,
  input  logic                TRIG_IN,
  input  logic [ADDR_W-1:0]   PRE_CNT,
  input  logic [7:0]          SMP_DIV,
  output logic                WR_EN,
  output logic [ADDR_W-1:0]   WR_ADDR,
  output logic [LA_SMP_W-1:0] WR_DATA,
  output logic [ADDR_W-1:0]   TRIG_ADDR,
  output logic                BUSY,
  output logic                DONE
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  logic [4:0]          state;
  logic [7:0]          div_cnt;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W:0]     cnt;
  logic [ADDR_W:0]     cnt_inc;
  logic [ADDR_W:0]     pre_tgt;
  logic [ADDR_W:0]     post_tgt;
  logic                trig_pend;
  logic                active;
  logic                strobe;
  logic                trig_hit;
  logic [LA_SMP_W-1:0] smp_d;

  la_delay_line #(.STAGES(TRIG_LAG)) u_dly (
    .CLK  (CLK),
    .RST  (RST),
    .DIN  (DATA_IN),
    .DOUT (smp_d)
  );

  assign active   = (state == ST_PRE) || (state == ST_WAIT) || (state == ST_POST);
  assign strobe   = active && (div_cnt == SMP_DIV);
  assign trig_hit = strobe && (state == ST_WAIT) && (trig_pend || TRIG_IN);
  assign cnt_inc  = cnt + ONE;
  assign pre_tgt  = {1'b0, PRE_CNT};
  // Extra bit so PRE_CNT=0 yields a full-depth post target.
  assign post_tgt = DEPTH - pre_tgt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_cnt <= '0;
    end else if ((state == ST_IDLE) || (div_cnt == SMP_DIV)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // A trigger between strobes is held so it binds to the next sample.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      trig_pend <= 1'b0;
    end else if ((state == ST_IDLE) || (state == ST_PRE) || strobe) begin
      trig_pend <= 1'b0;
    end else if (TRIG_IN) begin
      trig_pend <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      addr      <= '0;
      cnt       <= '0;
      WR_EN     <= 1'b0;
      WR_ADDR   <= '0;
      WR_DATA   <= '0;
      TRIG_ADDR <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else if (!EN) begin
      state <= ST_IDLE;
      WR_EN <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      WR_EN <= strobe;
      BUSY  <= active;
      DONE  <= (state == ST_DONE);
      if (strobe) begin
        WR_ADDR <= addr;
        WR_DATA <= smp_d;
        addr    <= addr + ADDR_W'(1);
      end
      case (state)
        ST_IDLE: begin
          addr  <= '0;
          cnt   <= '0;
          state <= (PRE_CNT == '0) ? ST_WAIT : ST_PRE;
        end
        ST_PRE: begin
          if (strobe) begin
            cnt <= cnt_inc;
            if (cnt_inc == pre_tgt) state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (trig_hit) begin
            TRIG_ADDR <= addr;
            cnt       <= ONE;
            state     <= (post_tgt == ONE) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (strobe) begin
            cnt <= cnt_inc;
            if (cnt_inc == post_tgt) state <= ST_DONE;
          end
        end
        ST_DONE: begin
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Bench for la_capture_ctrl: directed and random capture runs checked
// against a write-schedule model derived from strobe timing.
module tb_la_capture_ctrl;
  localparam int ADDR_W   = 4;
  localparam int TRIG_LAG = 2;
  localparam int DEPTH    = 16;
  localparam int OFF      = 3;
  localparam int MAXC     = 260;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              EN = 1'b0;
  logic              TRIG_IN = 1'b0;
  logic [7:0]        DATA_IN = '0;
  logic [7:0]        SMP_DIV = '0;
  logic [ADDR_W-1:0] PRE_CNT = '0;
  logic              WR_EN;
  logic              BUSY;
  logic              DONE;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [ADDR_W-1:0] TRIG_ADDR;
  logic [7:0]        WR_DATA;

  int checks = 0;
  int errors = 0;
  int exp_ta = 0;

  la_capture_ctrl #(.ADDR_W(ADDR_W), .TRIG_LAG(TRIG_LAG)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .DATA_IN   (DATA_IN),
    .TRIG_IN   (TRIG_IN),
    .PRE_CNT   (PRE_CNT),
    .SMP_DIV   (SMP_DIV),
    .WR_EN     (WR_EN),
    .WR_ADDR   (WR_ADDR),
    .WR_DATA   (WR_DATA),
    .TRIG_ADDR (TRIG_ADDR),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, exp_v);
    end
  endtask

  // One capture run. Arm at relative cycle 0; EN drops at cycle x (or at ncyc).
  // kind: 0 = single TRIG_IN pulse at tat, 1 = held from arm, 2 = random.
  task automatic run(input int p, input int d, input int ncyc, input int x_in,
                     input int kind, input int tat);
    logic [7:0] din [MAXC];
    bit         trg [MAXC];
    bit         we  [MAXC];
    int         ea  [MAXC];
    int         ed  [MAXC];
    int x, s, prev, trig_k, trig_s, last_s;
    bit e_busy, e_done;

    x = (x_in < ncyc) ? x_in : ncyc;
    for (int c = -OFF; c < ncyc; c++) begin
      din[c+OFF] = 8'($urandom);
      case (kind)
        0:       trg[c+OFF] = (c == tat);
        1:       trg[c+OFF] = (c >= 0);
        default: trg[c+OFF] = (c >= 0) && ($urandom_range(0, 9) == 0);
      endcase
    end
    for (int i = 0; i < MAXC; i++) begin
      we[i] = 1'b0;
      ea[i] = 0;
      ed[i] = 0;
    end

    // Write k lands on strobe cycle k*(d+1); triggers seen since the previous
    // strobe bind to it once the pre-trigger quota is met.
    trig_k = -1; trig_s = -1; last_s = -1; prev = 0;
    for (int k = 1; ; k++) begin
      s = (d + 1) * k;
      if (s >= x) break;
      if (s + 1 < ncyc) begin
        we[s+1+OFF] = 1'b1;
        ea[s+1+OFF] = (k - 1) % DEPTH;
        ed[s+1+OFF] = int'(din[s-TRIG_LAG+OFF]);
      end
      if (k > p && trig_k < 0) begin
        for (int c = prev + 1; c <= s; c++) if (trg[c+OFF]) trig_k = k;
        if (trig_k == k) trig_s = s;
      end
      if (trig_k > 0 && k == trig_k + DEPTH - p - 1) begin
        last_s = s;
        break;
      end
      prev = s;
    end

    for (int c = -OFF; c < ncyc; c++) begin
      @(negedge CLK);
      if (c > -OFF) begin
        e_busy = (c - 1 >= 1) && (c - 1 < x) && (last_s < 0 || c - 1 <= last_s);
        e_done = (last_s >= 0) && (c - 1 > last_s) && (c - 1 < x);
        if (trig_s >= 0 && c == trig_s + 1) exp_ta = (trig_k - 1) % DEPTH;
        chk("wr_en", c, 32'(WR_EN), 32'(we[c+OFF]));
        chk("busy", c, 32'(BUSY), 32'(e_busy));
        chk("done", c, 32'(DONE), 32'(e_done));
        chk("trig_addr", c, 32'(TRIG_ADDR), 32'(exp_ta));
        if (we[c+OFF]) begin
          chk("wr_addr", c, 32'(WR_ADDR), 32'(ea[c+OFF]));
          chk("wr_data", c, 32'(WR_DATA), 32'(ed[c+OFF]));
        end
      end
      PRE_CNT = ADDR_W'(p);
      SMP_DIV = 8'(d);
      EN      = (c >= 0) && (c < x);
      DATA_IN = din[c+OFF];
      TRIG_IN = trg[c+OFF];
    end
    if (trig_s >= 0) exp_ta = (trig_k - 1) % DEPTH;
  endtask

  initial begin
    #1 RST = 1'b0;
    #1;
    chk("rst_wr_en", 0, 32'(WR_EN), 32'd0);
    chk("rst_wr_addr", 0, 32'(WR_ADDR), 32'd0);
    chk("rst_wr_data", 0, 32'(WR_DATA), 32'd0);
    chk("rst_trig_addr", 0, 32'(TRIG_ADDR), 32'd0);
    chk("rst_busy", 0, 32'(BUSY), 32'd0);
    chk("rst_done", 0, 32'(DONE), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    run(4, 0, 60, 1000, 0, 20);     // basic capture
    run(3, 3, 90, 1000, 0, 26);     // decimation, trigger between strobes
    run(6, 1, 70, 1000, 1, 0);      // trigger held from arm
    run(0, 0, 40, 1000, 0, 5);      // full-depth post capture
    run(15, 0, 40, 1000, 0, 18);    // single post sample
    run(2, 0, 80, 1000, 0, 45);     // long wait with address wrap
    run(4, 1, 50, 30, 0, 20);       // abort during post
    run(3, 0, 40, 1000, 0, 10);     // re-arm after abort
    for (int i = 0; i < 4; i++)
      run(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 200, 1000, 2, 0);

    // Asynchronous reset while in post-trigger capture.
    run(4, 0, 14, 1000, 0, 8);
    @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("arst_wr_en", 0, 32'(WR_EN), 32'd0);
    chk("arst_wr_addr", 0, 32'(WR_ADDR), 32'd0);
    chk("arst_wr_data", 0, 32'(WR_DATA), 32'd0);
    chk("arst_trig_addr", 0, 32'(TRIG_ADDR), 32'd0);
    chk("arst_busy", 0, 32'(BUSY), 32'd0);
    chk("arst_done", 0, 32'(DONE), 32'd0);
    EN = 1'b0;
    TRIG_IN = 1'b0;
    exp_ta = 0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("post_rst_wr_en", i, 32'(WR_EN), 32'd0);
      chk("post_rst_busy", i, 32'(BUSY), 32'd0);
      chk("post_rst_done", i, 32'(DONE), 32'd0);
    end
    run(5, 2, 120, 1000, 0, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
